// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Widest operand the magnitude helper handles (dividend is 2*width bits).
  localparam int unsigned MAG_W = 64;

  // Iteration counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  // Two's-complement magnitude. The caller zero-extends its operand to MAG_W
  // bits and supplies the operand's own sign bit; the low operand-width bits
  // of the result are the magnitude, which covers the most-negative value.
  function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] x,
                                                input logic           neg);
    return neg ? (~x + MAG_W'(1)) : x;
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep the difference or restore.
module restoring_div_step #(
  parameter int width = 8
) (
  input  logic [width:0]   prem_i,
  input  logic             bit_i,
  input  logic [width-1:0] dmag_i,
  output logic [width:0]   prem_o,
  output logic             q_bit_o
);

  logic [width+1:0] shifted;
  logic [width+1:0] diff;

  // Trial subtraction; a clear borrow bit means the divisor fits.
  always_comb begin
    shifted = {prem_i, bit_i};
    diff    = shifted - {2'b00, dmag_i};
    q_bit_o = ~diff[width+1];
    prem_o  = q_bit_o ? diff[width:0] : shifted[width:0];
  end

endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: 2*width-bit dividend / width-bit divisor,
// quotient truncated toward zero, remainder takes the dividend's sign.
// Same en/done handshake as the sequential Booth multiplier.
module seq_signed_div
  import seq_div_pkg::*;
#(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2*width-1:0] N,
  input  logic [width-1:0]   D,
  output logic               done,
  output logic [width-1:0]   Q,
  output logic [width-1:0]   R,
  output logic               ovf,
  output logic               dz
);

  localparam int W2    = 2 * width;
  localparam int CNT_W = cnt_width(width);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width - 1);

  state_e             state_q, state_d;
  logic [width:0]     prem_q, prem_d;      // partial remainder
  logic [width-1:0]   n_lo_q, n_lo_d;      // low half of |N|, shifted out MSB-first
  logic [width-1:0]   d_mag_q, d_mag_d;
  logic [width-1:0]   quo_q, quo_d;        // unsigned quotient bits
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_i_q, dz_i_d;
  logic               ovf_u_q, ovf_u_d;
  logic               done_q, done_d;
  logic [width-1:0]   q_out_q, q_out_d;
  logic [width-1:0]   r_out_q, r_out_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;

  logic [W2-1:0]      n_mag;
  logic [width-1:0]   d_mag;
  logic [width:0]     prem_nxt;
  logic               q_bit;
  logic [width-1:0]   r_mag;
  logic               ovf_s;

  restoring_div_step #(.width(width)) u_step (
    .prem_i  (prem_q),
    .bit_i   (n_lo_q[width-1]),
    .dmag_i  (d_mag_q),
    .prem_o  (prem_nxt),
    .q_bit_o (q_bit)
  );

  // Operand magnitudes at the request inputs, used only on the start edge.
  always_comb begin
    n_mag = W2'(twos_mag(MAG_W'(N), N[W2-1]));
    d_mag = width'(twos_mag(MAG_W'(D), D[width-1]));
  end

  // Signed range check on the finished unsigned quotient.
  always_comb begin
    r_mag = prem_q[width-1:0];
    ovf_s = ovf_u_q |
            (q_neg_q ? (quo_q[width-1] & (|quo_q[width-2:0])) : quo_q[width-1]);
  end

  // Next-state and datapath control for IDLE -> CALC -> FIX -> HOLD.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d = state_q;
    prem_d  = prem_q;
    n_lo_d  = n_lo_q;
    d_mag_d = d_mag_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_i_d  = dz_i_q;
    ovf_u_d = ovf_u_q;
    done_d  = 1'b0;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          // The upper half of |N| seeds the remainder; if it is already
          // >= |D| the quotient cannot fit and ovf_u records that now.
          prem_d  = {1'b0, n_mag[W2-1:width]};
          n_lo_d  = n_mag[width-1:0];
          d_mag_d = d_mag;
          quo_d   = '0;
          cnt_d   = '0;
          q_neg_d = N[W2-1] ^ D[width-1];
          r_neg_d = N[W2-1];
          dz_i_d  = (D == '0);
          ovf_u_d = (D != '0) && (n_mag[W2-1:width] >= d_mag);
          state_d = CALC;
        end
      end
      CALC: begin
        // Runs all width steps even for dz/ovf so latency never varies.
        prem_d = prem_nxt;
        n_lo_d = n_lo_q << 1;
        quo_d  = {quo_q[width-2:0], q_bit};
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = HOLD;
        if (dz_i_q) begin
          q_out_d = '0;
          r_out_d = '0;
          dz_d    = 1'b1;
          ovf_d   = 1'b0;
        end else if (ovf_s) begin
          q_out_d = '0;
          r_out_d = '0;
          dz_d    = 1'b0;
          ovf_d   = 1'b1;
        end else begin
          q_out_d = q_neg_q ? (~quo_q + width'(1)) : quo_q;
          r_out_d = r_neg_q ? (~r_mag + width'(1)) : r_mag;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      HOLD: begin
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any division.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      prem_q  <= '0;
      n_lo_q  <= '0;
      d_mag_q <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_i_q  <= 1'b0;
      ovf_u_q <= 1'b0;
      done_q  <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      n_lo_q  <= n_lo_d;
      d_mag_q <= d_mag_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_i_q  <= dz_i_d;
      ovf_u_q <= ovf_u_d;
      done_q  <= done_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign done = done_q;
  assign Q    = q_out_q;
  assign R    = r_out_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_seq_signed_div.sv
// Directed bench for seq_signed_div (width = 8).
module tb_seq_signed_div;

  localparam int W   = 8;
  localparam int LAT = W + 2;  // start edge counted as clock 1

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [2*W-1:0] N;
  logic [W-1:0]   D;
  logic           done;
  logic [W-1:0]   Q;
  logic [W-1:0]   R;
  logic           ovf;
  logic           dz;

  int checks = 0;
  int errors = 0;

  seq_signed_div #(.width(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .N    (N),
    .D    (D),
    .done (done),
    .Q    (Q),
    .R    (R),
    .ovf  (ovf),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  // Issue one request, wait (bounded) for done, capture results, drop en.
  // lat is the number of clocks from the start edge (as 1) to done, or -1.
  task automatic run_div(input int n, input int d, output int lat,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic o, output logic z);
    @(negedge clk);
    N  = 16'(n);
    D  = 8'(d);
    en = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    q = Q;
    r = R;
    o = ovf;
    z = dz;
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    N   = '0;
    D   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, Q, R, ovf, dz} !== '0) begin
      errors++;
      $display("FAIL reset: done=%b Q=%0d R=%0d ovf=%b dz=%b want all 0",
               done, Q, R, ovf, dz);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_inverse();
    int n_t[4] = '{1000, 16384, -16256, 12700};
    int d_t[4] = '{-100, -128, 127, 127};
    int q_t[4] = '{-10, -128, -128, 100};
    int lat;
    logic [W-1:0] q, r;
    logic o, z;
    for (int i = 0; i < 4; i++) begin
      run_div(n_t[i], d_t[i], lat, q, r, o, z);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL inverse%0d latency: got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (q !== 8'(q_t[i])) begin
        errors++;
        $display("FAIL inverse%0d Q: got %0d want %0d", i, $signed(q), q_t[i]);
      end
      checks++;
      if (r !== 8'd0) begin
        errors++;
        $display("FAIL inverse%0d R: got %0d want 0", i, $signed(r));
      end
      checks++;
      if ({o, z} !== 2'b00) begin
        errors++;
        $display("FAIL inverse%0d flags: ovf=%b dz=%b want 0 0", i, o, z);
      end
    end
    // Results stay on the outputs after done has gone.
    checks++;
    if (Q !== 8'd100 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold: Q=%0d done=%b want 100 0", $signed(Q), done);
    end
  endtask

  task automatic test_trunc();
    int n_t[3] = '{7, -7, -7};
    int d_t[3] = '{-2, 2, -2};
    int q_t[3] = '{-3, -3, 3};
    int r_t[3] = '{1, -1, -1};
    int lat;
    logic [W-1:0] q, r;
    logic o, z;
    for (int i = 0; i < 3; i++) begin
      run_div(n_t[i], d_t[i], lat, q, r, o, z);
      checks++;
      if (q !== 8'(q_t[i]) || r !== 8'(r_t[i])) begin
        errors++;
        $display("FAIL trunc%0d: Q=%0d R=%0d want Q=%0d R=%0d",
                 i, $signed(q), $signed(r), q_t[i], r_t[i]);
      end
      checks++;
      if ({o, z} !== 2'b00 || lat !== LAT) begin
        errors++;
        $display("FAIL trunc%0d flags/lat: ovf=%b dz=%b lat=%0d want 0 0 %0d",
                 i, o, z, lat, LAT);
      end
    end
  endtask

  task automatic test_ovf();
    int n_t[4] = '{16384, -32768, 128, -128};
    int d_t[4] = '{1, -1, 1, 1};
    int q_t[4] = '{0, 0, 0, -128};
    logic o_t[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int lat;
    logic [W-1:0] q, r;
    logic o, z;
    for (int i = 0; i < 4; i++) begin
      run_div(n_t[i], d_t[i], lat, q, r, o, z);
      checks++;
      if (o !== o_t[i] || z !== 1'b0) begin
        errors++;
        $display("FAIL ovf%0d flags: ovf=%b dz=%b want %b 0", i, o, z, o_t[i]);
      end
      checks++;
      if (q !== 8'(q_t[i]) || r !== 8'd0) begin
        errors++;
        $display("FAIL ovf%0d values: Q=%0d R=%0d want Q=%0d R=0",
                 i, $signed(q), $signed(r), q_t[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [W-1:0] q, r;
    logic o, z;
    run_div(55, 0, lat, q, r, o, z);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL dz latency: got %0d want %0d", lat, LAT);
    end
    checks++;
    if (z !== 1'b1 || o !== 1'b0) begin
      errors++;
      $display("FAIL dz flags: dz=%b ovf=%b want 1 0", z, o);
    end
    checks++;
    if (q !== 8'd0 || r !== 8'd0) begin
      errors++;
      $display("FAIL dz values: Q=%0d R=%0d want 0 0", $signed(q), $signed(r));
    end
  endtask

  task automatic test_handshake();
    int pulses = 0;
    int lat = -1;
    @(negedge clk);
    N  = 16'(-100);
    D  = 8'(9);
    en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL handshake pulses: got %0d want 1", pulses);
    end
    checks++;
    if (Q !== 8'(-11) || R !== 8'(-1)) begin
      errors++;
      $display("FAIL handshake first: Q=%0d R=%0d want -11 -1",
               $signed(Q), $signed(R));
    end
    en = 1'b0;
    @(negedge clk);
    N  = 16'(50);
    D  = 8'(-7);
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== LAT || Q !== 8'(-7) || R !== 8'd1) begin
      errors++;
      $display("FAIL handshake second: lat=%0d Q=%0d R=%0d want %0d -7 1",
               lat, $signed(Q), $signed(R), LAT);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat;
    logic [W-1:0] q, r;
    logic o, z;
    @(negedge clk);
    N  = 16'(1000);
    D  = 8'(3);
    en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({done, Q, R, ovf, dz} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: done=%b Q=%0d R=%0d ovf=%b dz=%b want all 0",
               done, $signed(Q), $signed(R), ovf, dz);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid aborted: got %0d done pulses want 0", seen);
    end
    run_div(100, 7, lat, q, r, o, z);
    checks++;
    if (q !== 8'd14 || r !== 8'd2 || {o, z} !== 2'b00 || lat !== LAT) begin
      errors++;
      $display("FAIL reset_mid next: Q=%0d R=%0d ovf=%b dz=%b lat=%0d want 14 2 0 0 %0d",
               $signed(q), $signed(r), o, z, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_inverse();
    test_trunc();
    test_ovf();
    test_div_zero();
    test_handshake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
